// File: rtl/uart_packet_rx.sv
// uart_packet_rx: deframes SYNC, LEN, payload, CSUM packets from a UART byte
// stream. Payload bytes are streamed out as they arrive; each packet ends in
// exactly one pkt_ok or pkt_err strobe. An inter-byte timeout aborts
// truncated packets.
//
// state     | meaning
// ----------|-----------------------------------------------
// S_IDLE    | hunting for SYNC_BYTE, other bytes discarded
// S_LEN     | next byte is the payload length
// S_PAYLOAD | streaming payload, remaining_q bytes to go
// S_CSUM    | next byte is the checksum (LEN + payload, mod 256)
module uart_packet_rx #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          MAX_LEN      = 16,
  parameter logic [15:0] TIMEOUT_CLKS = 16'd3472
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       ready,
  input  logic       frame_err,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic [7:0] pkt_len
);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM} state_t;

  localparam logic [8:0] MAX_LEN_L  = 9'(MAX_LEN);
  localparam logic [1:0] ERR_LEN    = 2'd0;
  localparam logic [1:0] ERR_CSUM   = 2'd1;
  localparam logic [1:0] ERR_FRAME  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  state_t      state_q;
  logic        ready_q;
  logic [15:0] timer_q;
  logic [15:0] timer_d;
  logic [7:0]  sum_q;
  logic [7:0]  remaining_q;
  logic [7:0]  data_out_q;
  logic        data_valid_q;
  logic        pkt_ok_q;
  logic        pkt_err_q;
  logic [1:0]  err_code_q;
  logic [7:0]  pkt_len_q;
  logic        strobe;

  assign strobe  = ready & ~ready_q;
  assign timer_d = timer_q + 16'd1;

  // Parser FSM, inter-byte timer and registered output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      timer_q      <= '0;
      sum_q        <= '0;
      remaining_q  <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      pkt_ok_q     <= 1'b0;
      pkt_err_q    <= 1'b0;
      err_code_q   <= '0;
      pkt_len_q    <= '0;
    end else begin
      ready_q      <= ready;
      data_valid_q <= 1'b0;
      pkt_ok_q     <= 1'b0;
      pkt_err_q    <= 1'b0;
      if (strobe) begin
        timer_q <= '0;
        if (state_q != S_IDLE && frame_err) begin
          pkt_err_q  <= 1'b1;
          err_code_q <= ERR_FRAME;
          state_q    <= S_IDLE;
        end else begin
          case (state_q)
            S_IDLE: begin
              if (rx_byte == SYNC_BYTE && !frame_err) state_q <= S_LEN;
            end
            S_LEN: begin
              pkt_len_q <= rx_byte;
              if (rx_byte == 8'd0 || {1'b0, rx_byte} > MAX_LEN_L) begin
                pkt_err_q  <= 1'b1;
                err_code_q <= ERR_LEN;
                state_q    <= S_IDLE;
              end else begin
                sum_q       <= rx_byte;
                remaining_q <= rx_byte;
                state_q     <= S_PAYLOAD;
              end
            end
            S_PAYLOAD: begin
              data_out_q   <= rx_byte;
              data_valid_q <= 1'b1;
              sum_q        <= sum_q + rx_byte;
              remaining_q  <= remaining_q - 8'd1;
              if (remaining_q == 8'd1) state_q <= S_CSUM;
            end
            S_CSUM: begin
              if (rx_byte == sum_q) begin
                pkt_ok_q <= 1'b1;
              end else begin
                pkt_err_q  <= 1'b1;
                err_code_q <= ERR_CSUM;
              end
              state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end else if (state_q != S_IDLE) begin
        if (timer_d == TIMEOUT_CLKS) begin
          pkt_err_q  <= 1'b1;
          err_code_q <= ERR_TIMEOUT;
          state_q    <= S_IDLE;
          timer_q    <= '0;
        end else begin
          timer_q <= timer_d;
        end
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign pkt_ok     = pkt_ok_q;
  assign pkt_err    = pkt_err_q;
  assign err_code   = err_code_q;
  assign pkt_len    = pkt_len_q;

endmodule

// File: tb/tb_uart_packet_rx.sv
// Testbench for uart_packet_rx: directed vector table, hand-written corner
// sequences, and a randomized byte stream checked against a packet-level model.
module tb_uart_packet_rx;
  localparam int         T    = 3472;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       ready = 1'b0;
  logic       frame_err = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       pkt_ok;
  logic       pkt_err;
  logic [1:0] err_code;
  logic [7:0] pkt_len;

  uart_packet_rx dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .ready(ready), .frame_err(frame_err),
    .data_out(data_out), .data_valid(data_valid), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
    .err_code(err_code), .pkt_len(pkt_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: pulse counters and, when enabled, an event log.
  typedef struct {int kind; int data; int len; int at;} ev_t;
  ev_t obs[$];
  bit  rec_en = 1'b0;
  int  n_dv = 0, n_ok = 0, n_err = 0, n_excl = 0;
  int  last_err_at = 0, last_err_code = 0;

  always @(negedge clk) begin
    if (data_valid) begin
      n_dv++;
      if (rec_en) obs.push_back('{0, int'(data_out), 0, cyc});
    end
    if (pkt_ok) begin
      n_ok++;
      if (rec_en) obs.push_back('{1, 0, int'(pkt_len), cyc});
    end
    if (pkt_err) begin
      n_err++;
      last_err_at   = cyc;
      last_err_code = int'(err_code);
      if (rec_en) obs.push_back('{2, int'(err_code), int'(pkt_len), cyc});
    end
    if (pkt_ok && pkt_err) n_excl++;
  end

  int last_at = 0;

  // One byte: ready rises, the strobe edge passes, ready drops again.
  task automatic drive(input logic [7:0] b, input bit fe);
    @(posedge clk); #1;
    rx_byte = b; frame_err = fe; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0; frame_err = 1'b0;
    last_at = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] outs_now();
    return 64'({data_out, data_valid, pkt_ok, pkt_err, err_code, pkt_len});
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0] b; bit fe; int gap;
    bit dv; logic [7:0] d; bit ok; bit err; logic [1:0] code; logic [7:0] len;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic [7:0] b, input bit fe, input int gap, input bit dv,
                     input logic [7:0] d, input bit ok, input bit err,
                     input logic [1:0] code, input logic [7:0] len);
    vt.push_back('{b, fe, gap, dv, d, ok, err, code, len});
  endtask

  task automatic run_table();
    logic [20:0] act, exp;
    // good packet, 347 clocks between strobes
    add(8'hA5,0,345, 0,8'h00,0,0,0,8'h00);
    add(8'h03,0,345, 0,8'h00,0,0,0,8'h03);
    add(8'h11,0,345, 1,8'h11,0,0,0,8'h03);
    add(8'h22,0,345, 1,8'h22,0,0,0,8'h03);
    add(8'h33,0,345, 1,8'h33,0,0,0,8'h03);
    add(8'h69,0,3,   0,8'h00,1,0,0,8'h03);
    // bad checksum, SYNC as data, then a good one
    add(8'hA5,0,2, 0,8'h00,0,0,0,8'h03);
    add(8'h02,0,2, 0,8'h00,0,0,0,8'h02);
    add(8'hA5,0,2, 1,8'hA5,0,0,0,8'h02);
    add(8'h01,0,2, 1,8'h01,0,0,0,8'h02);
    add(8'h00,0,2, 0,8'h00,0,1,1,8'h02);
    add(8'hA5,0,0, 0,8'h00,0,0,0,8'h02);
    add(8'h01,0,0, 0,8'h00,0,0,0,8'h01);
    add(8'h7F,0,0, 1,8'h7F,0,0,0,8'h01);
    add(8'h80,0,2, 0,8'h00,1,0,0,8'h01);
    // length limits
    add(8'hA5,0,2, 0,8'h00,0,0,0,8'h01);
    add(8'h00,0,2, 0,8'h00,0,1,0,8'h00);
    add(8'hA5,0,2, 0,8'h00,0,0,0,8'h00);
    add(8'h11,0,2, 0,8'h00,0,1,0,8'h11);
    add(8'hA5,0,1, 0,8'h00,0,0,0,8'h11);
    add(8'h10,0,1, 0,8'h00,0,0,0,8'h10);
    for (int i = 0; i < 16; i++) add(8'h01,0,1, 1,8'h01,0,0,0,8'h10);
    add(8'h20,0,2, 0,8'h00,1,0,0,8'h10);
    // IDLE noise, framing errors (in payload, in IDLE, on a completing CSUM)
    add(8'h33,0,2, 0,8'h00,0,0,0,8'h10);
    add(8'h44,0,2, 0,8'h00,0,0,0,8'h10);
    add(8'hA5,0,2, 0,8'h00,0,0,0,8'h10);
    add(8'h02,0,2, 0,8'h00,0,0,0,8'h02);
    add(8'h11,1,2, 0,8'h00,0,1,2,8'h02);
    add(8'hA5,1,2, 0,8'h00,0,0,0,8'h02);
    add(8'h01,0,2, 0,8'h00,0,0,0,8'h02);
    add(8'hA5,0,2, 0,8'h00,0,0,0,8'h02);
    add(8'h01,0,2, 0,8'h00,0,0,0,8'h01);
    add(8'h05,0,2, 1,8'h05,0,0,0,8'h01);
    add(8'h06,1,4, 0,8'h00,0,1,2,8'h01);
    foreach (vt[i]) begin
      drive(vt[i].b, vt[i].fe);
      act = {data_valid, data_valid ? data_out : 8'h00, pkt_ok, pkt_err,
             pkt_err ? err_code : 2'b00, pkt_len};
      exp = {vt[i].dv, vt[i].d, vt[i].ok, vt[i].err, vt[i].code, vt[i].len};
      check($sformatf("vec%0d", i), 64'(act), 64'(exp));
      idle(vt[i].gap);
    end
  endtask

  // ---------------- hand-written corner sequences ----------------
  task automatic run_hand();
    int e, base_dv, base_ok, base_err, waited;
    // timeout exactly T clocks after the last payload strobe
    base_err = n_err;
    drive(SYNC,0); drive(8'h02,0); drive(8'h11,0);
    e = last_at;
    waited = 0;
    while (n_err == base_err && waited < T + 50) begin idle(1); waited++; end
    check("timeout_seen", 64'(n_err - base_err), 64'd1);
    check("timeout_delay", 64'(last_err_at - e), 64'(T));
    check("timeout_code", 64'(last_err_code), 64'd3);
    // silence in IDLE stays quiet, parser accepts a fresh packet
    base_err = n_err; base_ok = n_ok;
    idle(T + 20);
    drive(SYNC,0); drive(8'h01,0); drive(8'h7F,0); drive(8'h80,0); idle(2);
    check("idle_silence_err", 64'(n_err - base_err), 64'd0);
    check("after_timeout_ok", 64'(n_ok - base_ok), 64'd1);
    // strobe arriving on the very last allowed clock wins over the timeout
    base_err = n_err; base_ok = n_ok;
    drive(SYNC,0); drive(8'h01,0); idle(T - 2);
    drive(8'h7F,0); idle(T - 2);
    drive(8'h80,0); idle(2);
    check("edge_strobe_wins_err", 64'(n_err - base_err), 64'd0);
    check("edge_strobe_wins_ok", 64'(n_ok - base_ok), 64'd1);
    // reset mid-payload abandons the packet silently
    drive(SYNC,0); drive(8'h04,0); drive(8'h11,0); idle(1);
    base_dv = n_dv; base_ok = n_ok; base_err = n_err;
    rst = 1'b1; idle(3); rst = 1'b0; idle(2);
    check("mid_reset_outputs", outs_now(), 64'd0);
    drive(8'h22,0); drive(8'h33,0); idle(T + 20);
    check("mid_reset_dv", 64'(n_dv - base_dv), 64'd0);
    check("mid_reset_pkt", 64'(n_ok + n_err - base_ok - base_err), 64'd0);
    // ready held high across reset release is not a byte
    @(posedge clk); #1;
    rst = 1'b1; rx_byte = SYNC; ready = 1'b1;
    idle(2); rst = 1'b0; idle(5);
    ready = 1'b0; idle(2);
    base_dv = n_dv; base_ok = n_ok;
    drive(8'h01,0); drive(8'h7F,0); drive(8'h80,0); idle(2);
    check("held_ready_dv", 64'(n_dv - base_dv), 64'd0);
    check("held_ready_ok", 64'(n_ok - base_ok), 64'd0);
    drive(SYNC,0); drive(8'h01,0); drive(8'h7F,0); drive(8'h80,0); idle(2);
    check("held_ready_then_ok", 64'(n_ok - base_ok), 64'd1);
  endtask

  // ---------------- random stream vs packet-level model ----------------
  typedef struct {logic [7:0] b; bit fe; int at;} st_t;
  st_t  sq[$];
  ev_t  exq[$];

  task automatic model(input int end_at, input int start_len);
    int ph = 0, len = 0, last = 0, plen = start_len, s;
    logic [7:0] pay[$];
    foreach (sq[i]) begin
      if (ph != 0 && sq[i].at - last > T) begin
        exq.push_back('{2, 3, plen, last + T}); ph = 0;
      end
      last = sq[i].at;
      if (ph != 0 && sq[i].fe) begin
        exq.push_back('{2, 2, plen, sq[i].at}); ph = 0;
      end else if (ph == 0) begin
        if (sq[i].b == SYNC && !sq[i].fe) ph = 1;
      end else if (ph == 1) begin
        plen = int'(sq[i].b);
        if (plen == 0 || plen > 16) begin
          exq.push_back('{2, 0, plen, sq[i].at}); ph = 0;
        end else begin
          len = plen; pay.delete(); ph = 2;
        end
      end else if (ph == 2) begin
        exq.push_back('{0, int'(sq[i].b), 0, sq[i].at});
        pay.push_back(sq[i].b);
        if (pay.size() == len) ph = 3;
      end else begin
        s = len;
        foreach (pay[j]) s += int'(pay[j]);
        if (int'(sq[i].b) == s % 256) exq.push_back('{1, 0, plen, sq[i].at});
        else exq.push_back('{2, 1, plen, sq[i].at});
        ph = 0;
      end
    end
    if (ph != 0 && end_at - last > T) exq.push_back('{2, 3, plen, last + T});
  endtask

  task automatic run_random();
    logic [7:0] bl[$];
    bit         fl[$];
    int r, len, k, rr, g, n;
    logic [7:0] s, pb;
    rec_en = 1'b1;
    for (int it = 0; it < 40; it++) begin
      bl.delete(); fl.delete();
      r = $urandom_range(0, 9);
      if (r == 0) begin
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) begin
          pb = 8'($urandom);
          if (pb == SYNC) pb = 8'h5A;
          bl.push_back(pb); fl.push_back(1'($urandom));
        end
      end else begin
        if (r == 1) len = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(17, 255);
        else        len = $urandom_range(1, 16);
        bl.push_back(SYNC); fl.push_back(1'b0);
        bl.push_back(8'(len)); fl.push_back(1'b0);
        if (len >= 1 && len <= 16) begin
          s = 8'(len);
          for (int j = 0; j < len; j++) begin
            pb = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom);
            bl.push_back(pb); fl.push_back(1'b0);
            s = s + pb;
          end
          if (r == 2) s = s ^ 8'($urandom_range(1, 255));
          bl.push_back(s); fl.push_back(1'b0);
        end
        if (r == 3) begin
          k = $urandom_range(1, bl.size() - 1);
          fl[k] = 1'b1;
        end
      end
      foreach (bl[j]) begin
        drive(bl[j], fl[j]);
        sq.push_back('{bl[j], fl[j], last_at});
        rr = $urandom_range(0, 59);
        g  = (rr == 0) ? T - 2 : (rr == 1) ? T - 1 : (rr == 2) ? T + 5 : $urandom_range(0, 4);
        idle(g);
      end
    end
    idle(T + 20);
    rec_en = 1'b0;
    model(cyc, 1);
    check("rand_event_count", 64'(obs.size()), 64'(exq.size()));
    n = (obs.size() < exq.size()) ? obs.size() : exq.size();
    for (int i = 0; i < n; i++)
      check($sformatf("rand_ev%0d kind/data/len/at", i),
            {8'(obs[i].kind), 8'(obs[i].data), 8'(obs[i].len), 32'(obs[i].at)},
            {8'(exq[i].kind), 8'(exq[i].data), 8'(exq[i].len), 32'(exq[i].at)});
  endtask

  initial begin
    idle(4);
    check("reset_outputs", outs_now(), 64'd0);
    rst = 1'b0;
    idle(3);
    check("post_reset_outputs", outs_now(), 64'd0);
    run_table();
    run_hand();
    run_random();
    check("ok_err_exclusive", 64'(n_excl), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_packet_rx.md
# uart_packet_rx

Byte-to-packet deframer that sits directly downstream of `high_speed_uart` on the receive side. It consumes the `rx_byte`/`ready`/`frame_err` outputs, locates packets of the form SYNC, LEN, payload, CSUM, and streams payload bytes to the application. It reports each packet as good or bad with an error code, and it enforces an inter-byte timeout so that a truncated packet cannot hang the parser. Operating point: 32 MHz `clk`, 921600 baud link, about 347 clocks per UART byte.

## Interface

Parameters:
- `SYNC_BYTE`, default 8'hA5: packet start marker.
- `MAX_LEN`, default 16: largest legal payload length; legal range is 1..255.
- `TIMEOUT_CLKS`, default 3472: idle clocks allowed between bytes inside a packet, about 10 byte times; width is 16 bits.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, 32 MHz.
- `rst`  in  1  synchronous active-high reset.
- `rx_byte`  in  8  received byte from the UART.
- `ready`  in  1  UART byte-available flag; a new byte is signalled by a rising edge.
- `frame_err`  in  1  UART framing error, qualified by the same rising edge of `ready`.
- `data_out`  out  8  payload byte.
- `data_valid`  out  1  one-cycle strobe; `data_out` is valid while it is high.
- `pkt_ok`  out  1  one-cycle strobe; the packet is complete and its checksum matched.
- `pkt_err`  out  1  one-cycle strobe; the packet was aborted.
- `err_code`  out  2  reason for `pkt_err`, valid with it: 0 bad length, 1 checksum mismatch, 2 framing error, 3 timeout.
- `pkt_len`  out  8  LEN of the last completed or aborted packet; updated when LEN is accepted.

## Operation

Byte strobe:
- `ready_d` is a registered copy of `ready`; `strobe = ready & ~ready_d`.
- `ready_d` resets to 1. A `ready` already high at reset release therefore produces no strobe until it has been seen low and then high again.

States:
- **IDLE**: on a strobe with `rx_byte == SYNC_BYTE` and `frame_err == 0`, go to LEN. All other bytes, including bytes with `frame_err`, are silently discarded; no error is reported.
- **LEN**: on a strobe:
  - Capture `pkt_len`.
  - If LEN is 0 or greater than `MAX_LEN`: `pkt_err`, code 0, go to IDLE.
  - Otherwise set `sum = LEN`, set `remaining = LEN`, go to PAYLOAD.
- **PAYLOAD**: on each strobe:
  - Drive `data_out = rx_byte` and pulse `data_valid`.
  - `sum += rx_byte`, modulo 256; `remaining -= 1`.
  - When `remaining` reaches 0, go to CSUM.
  - A byte equal to `SYNC_BYTE` is ordinary data here.
- **CSUM**: on a strobe:
  - If `rx_byte == sum`: pulse `pkt_ok`.
  - Otherwise: `pkt_err`, code 1.
  - Go to IDLE in both cases.

Errors and timeout:
- A `frame_err` on any strobe in LEN, PAYLOAD or CSUM gives `pkt_err`, code 2, and a return to IDLE. The byte is not emitted and not summed.
- The timeout counter clears on every strobe and counts up in every state except IDLE. On reaching `TIMEOUT_CLKS` it gives `pkt_err`, code 3, and a return to IDLE.
- The application must discard any payload already streamed for a packet that ends in `pkt_err`.

Reset values:
- `data_out`, `data_valid`, `pkt_ok`, `pkt_err`, `err_code`, `pkt_len` all reset to 0.
- State resets to IDLE; the counters and `sum` reset to 0.
- A reset in the middle of a packet abandons it with no strobe.

## Timing

- A strobe occurs in the cycle N in which `ready` is first seen high. `data_valid`, `pkt_ok` and `pkt_err` are registered and rise in cycle N+1, each for exactly 1 cycle.
- The state change takes effect at the end of cycle N, so the next byte can be accepted from cycle N+1. Back-to-back strobes two cycles apart must work.
- Timeout and strobe in the same cycle: the strobe wins and the counter clears.
- `frame_err` and a completing CSUM in the same strobe: code 2, with no `pkt_ok`.
- `pkt_ok` and `pkt_err` are never high in the same cycle. At most one of the two is produced per packet.
- Outputs are pure registers: no combinational path from inputs to outputs.

## Test plan

1. **Good packet.** Drive A5 03 11 22 33 69 with 347 clocks between strobes. Expect `data_valid` ×3 with `data_out` 11, 22, 33; `pkt_ok` one cycle after the 69 strobe; `pkt_len` = 3; no `pkt_err`.
2. **Bad checksum.** Drive A5 02 A5 01 00. Expect `data_out` A5, 01 (SYNC treated as data), then `pkt_err` with code 1 and no `pkt_ok`. A following A5 01 7F 80 must give `pkt_ok`.
3. **Length limits.** Drive A5 00, then A5 11 (17 > 16). Expect `pkt_err` code 0 twice and no `data_valid`. Drive A5 10, 16 bytes of 01, then 20. Expect `pkt_ok`.
4. **Framing error and IDLE noise.** Drive 33 44 in IDLE: nothing happens. Drive A5 02 11 with `frame_err` = 1 on the third strobe. Expect `pkt_err` code 2 and 0 `data_valid` pulses for that byte.
5. **Timeout.** Drive A5 02 11, then silence. Expect `pkt_err` code 3 exactly 3472 clocks after the 11 strobe; the parser returns to IDLE. Silence in IDLE produces no error.
6. **Reset behaviour.**
   - Assert `rst` mid-payload: no strobes during or after reset.
   - Hold `ready` high across reset release: no byte is accepted until `ready` toggles.
   - After reset, all outputs read 0.
